// File: rtl/hash_core_arbiter.sv
// rtl/hash_core_arbiter.sv - round-robin sequencer sharing one hash core among NUM_REQ requesters
// Optional WAIT abort counter built when HCA_TIMEOUT_EN is defined.
module hash_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 512,
  parameter int RES_W          = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_data,
  input  logic                      core_data_ready,
  input  logic [RES_W-1:0]          core_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      busy
`ifdef HCA_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("hash_core_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   owner_inc;
  logic [PTR_W-1:0]   grant;
  logic               grant_found;
  logic [PTR_W:0]     idx_sum;
  logic               dr_q;
  logic               rise;
  logic               rsp_done;
  logic               to_hit;

`ifdef HCA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt;
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Rotating priority search starting at rr_ptr
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(NUM_REQ)) idx_sum = idx_sum - (PTR_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[idx_sum[PTR_W-1:0]]) begin
        grant       = idx_sum[PTR_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign rise      = (state == S_WAIT) && core_data_ready && !dr_q;
  assign rsp_done  = (state == S_RESP) && rsp_ready[owner];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_found) state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (rise) state_next = S_RESP;
               else if (to_hit) state_next = S_IDLE;
      S_RESP:  if (rsp_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = (state == S_START);
    busy       = (state != S_IDLE);
    if (state == S_IDLE && grant_found) req_ready = NUM_REQ'(1) << grant;
    if (state == S_RESP) rsp_valid = NUM_REQ'(1) << owner;
  end

  // A level already high at START is recorded in dr_q so it is not taken as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      owner      <= '0;
      core_data  <= '0;
      rsp_result <= '0;
      dr_q       <= 1'b0;
`ifdef HCA_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef HCA_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: if (grant_found) begin
          owner     <= grant;
          core_data <= req_data[grant*DATA_W +: DATA_W];
        end
        S_START: begin
          dr_q <= core_data_ready;
`ifdef HCA_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT: begin
          dr_q <= core_data_ready;
`ifdef HCA_TIMEOUT_EN
          to_cnt <= to_cnt + CNT_W'(1);
`endif
          if (rise) begin
            rsp_result <= core_result;
          end else if (to_hit) begin
            rr_ptr <= owner_inc;
`ifdef HCA_TIMEOUT_EN
            timeout_err <= 1'b1;
`endif
          end
        end
        S_RESP: if (rsp_done) rr_ptr <= owner_inc;
        default: ;
      endcase
    end
  end

endmodule
